// File: rtl/axil_pkg.sv
// Shared encodings for the AXI4-Lite SRAM controller: response codes and FSM states.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StWrResp = 2'd1;
  localparam state_t StRdData = 2'd2;

endpackage

// File: rtl/axil_sram_ctrl_if.sv
// AXI4-Lite slave channel bundle; the controller takes the slave modport.
interface axil_sram_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0]   S_AWADDR;
  logic                S_AWVALID;
  logic                S_AWREADY;
  logic [DATA_W-1:0]   S_WDATA;
  logic [DATA_W/8-1:0] S_WSTRB;
  logic                S_WVALID;
  logic                S_WREADY;
  logic [1:0]          S_BRESP;
  logic                S_BVALID;
  logic                S_BREADY;
  logic [ADDR_W-1:0]   S_ARADDR;
  logic                S_ARVALID;
  logic                S_ARREADY;
  logic [DATA_W-1:0]   S_RDATA;
  logic [1:0]          S_RRESP;
  logic                S_RVALID;
  logic                S_RREADY;

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    output S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    input  S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/axil_sram_bank.sv
// Byte-write-enabled word array with one write port and one registered read port.
module axil_sram_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wstrb_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    // Output only moves on a read, so it holds across a stalled response.
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_sram_ctrl.sv
// AXI4-Lite slave in front of an internal SRAM bank; one transaction in flight,
// independent AW/W holding registers, round-robin write/read arbitration.
module axil_sram_ctrl
  import axil_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input logic              ACLK,
  input logic              ARESET,
  axil_sram_ctrl_if.slave  s
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic               prio_q, prio_d;  // 0: favour write, 1: favour read
  logic               aw_held_q, w_held_q;
  logic [ADDR_W-1:0]  aw_addr_q;
  logic [DATA_W-1:0]  w_data_q;
  logic [StrbW-1:0]   w_strb_q;
  logic [1:0]         bresp_q, rresp_q;
  logic [DATA_W-1:0]  bank_rdata;

  logic awready, wready, in_idle, wr_elig, rd_elig, wr_grant, rd_grant;
  logic aw_oor, ar_oor, bvalid, rvalid;
  logic unused_addr_bits;

  assign awready  = !aw_held_q && !ARESET;
  assign wready   = !w_held_q && !ARESET;
  assign in_idle  = (state_q == StIdle);
  assign wr_elig  = in_idle && aw_held_q && w_held_q;
  assign rd_elig  = in_idle && s.S_ARVALID && !ARESET;
  assign wr_grant = wr_elig && (!rd_elig || !prio_q);
  assign rd_grant = rd_elig && !wr_grant;
  assign aw_oor   = (aw_addr_q >> (OffW + IdxW)) != '0;
  assign ar_oor   = (s.S_ARADDR >> (OffW + IdxW)) != '0;
  assign bvalid   = (state_q == StWrResp);
  assign rvalid   = (state_q == StRdData);

  assign unused_addr_bits = ^{aw_addr_q[OffW-1:0], s.S_ARADDR[OffW-1:0]};

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      StIdle: begin
        if (wr_grant) begin
          state_d = StWrResp;
          prio_d  = 1'b1;
        end else if (rd_grant) begin
          state_d = StRdData;
          prio_d  = 1'b0;
        end
      end
      StWrResp: if (s.S_BREADY) state_d = StIdle;
      StRdData: if (s.S_RREADY) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= StIdle;
      prio_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (wr_grant) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= aw_oor ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (awready && s.S_AWVALID) begin
          aw_held_q <= 1'b1;
          aw_addr_q <= s.S_AWADDR;
        end
        if (wready && s.S_WVALID) begin
          w_held_q <= 1'b1;
          w_data_q <= s.S_WDATA;
          w_strb_q <= s.S_WSTRB;
        end
      end
      if (rd_grant) rresp_q <= ar_oor ? RESP_SLVERR : RESP_OKAY;
    end
  end

  axil_sram_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk_i   (ACLK),
    .we_i    (wr_grant && !aw_oor),
    .waddr_i (aw_addr_q[OffW +: IdxW]),
    .wdata_i (w_data_q),
    .wstrb_i (w_strb_q),
    .re_i    (rd_grant && !ar_oor),
    .raddr_i (s.S_ARADDR[OffW +: IdxW]),
    .rdata_o (bank_rdata)
  );

  assign s.S_AWREADY = awready;
  assign s.S_WREADY  = wready;
  assign s.S_ARREADY = rd_grant;
  assign s.S_BVALID  = bvalid;
  assign s.S_BRESP   = bresp_q;
  assign s.S_RVALID  = rvalid;
  assign s.S_RRESP   = rresp_q;
  assign s.S_RDATA   = (rvalid && rresp_q == RESP_OKAY) ? bank_rdata : '0;

endmodule

// File: tb/tb_axil_sram_ctrl.sv
// Directed bench for axil_sram_ctrl: vector table of write/read-back pairs plus
// hand sequences for early W, arbitration order, stalled R and async reset.
module tb_axil_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axil_sram_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  axil_sram_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .s      (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_bresp(input logic [1:0] resp, input string tag);
    int n = 0;
    while (!bus.S_BVALID && n < 20) begin
      step();
      n++;
    end
    chk({tag, " bvalid"}, bus.S_BVALID, 1);
    chk({tag, " bresp"}, bus.S_BRESP, resp);
    bus.S_BREADY = 1'b1;
    step();
    bus.S_BREADY = 1'b0;
    chk({tag, " bvalid drop"}, bus.S_BVALID, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp, input string tag);
    step();
    bus.S_AWADDR = addr;  bus.S_AWVALID = 1'b1;
    bus.S_WDATA  = data;  bus.S_WSTRB   = strb;  bus.S_WVALID = 1'b1;
    #1;
    chk({tag, " awready"}, bus.S_AWREADY, 1);
    chk({tag, " wready"}, bus.S_WREADY, 1);
    step();
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID  = 1'b0;
    wait_bresp(resp, tag);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input string tag);
    int n = 0;
    step();
    bus.S_ARADDR = addr;
    bus.S_ARVALID = 1'b1;
    #1;
    while (!bus.S_ARREADY && n < 20) begin
      step();
      n++;
    end
    chk({tag, " arready"}, bus.S_ARREADY, 1);
    step();
    bus.S_ARVALID = 1'b0;
    chk({tag, " rvalid latency"}, bus.S_RVALID, 1);
    chk({tag, " rdata"}, bus.S_RDATA, data);
    chk({tag, " rresp"}, bus.S_RRESP, resp);
    bus.S_RREADY = 1'b1;
    step();
    bus.S_RREADY = 1'b0;
    chk({tag, " rvalid drop"}, bus.S_RVALID, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] gr;
    int ng;
    int n;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{32'h0000_0020, 32'hCAFE_F00D, 4'hF, 2'b00, 32'hCAFE_F00D, 2'b00};
    vecs[2] = '{32'h0000_0022, 32'h1234_5678, 4'hC, 2'b00, 32'h1234_F00D, 2'b00};
    vecs[3] = '{32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'hA5A5_A5A5, 2'b00};
    vecs[4] = '{32'h0000_0000, 32'h0102_0304, 4'hF, 2'b00, 32'h0102_0304, 2'b00};
    vecs[5] = '{32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
    vecs[7] = '{32'h0000_0001, 32'h0000_00AA, 4'h1, 2'b00, 32'h0102_03AA, 2'b00};

    bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0; bus.S_WDATA = '0; bus.S_WSTRB = '0;
    bus.S_WVALID = 1'b0; bus.S_BREADY = 1'b0; bus.S_ARADDR = '0; bus.S_ARVALID = 1'b0;
    bus.S_RREADY = 1'b0;

    // Reset state
    #3;
    chk("rst awready", bus.S_AWREADY, 0);
    chk("rst wready", bus.S_WREADY, 0);
    chk("rst arready", bus.S_ARREADY, 0);
    chk("rst bvalid", bus.S_BVALID, 0);
    chk("rst rvalid", bus.S_RVALID, 0);
    chk("rst bresp", bus.S_BRESP, 0);
    chk("rst rresp", bus.S_RRESP, 0);
    chk("rst rdata", bus.S_RDATA, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post-rst awready", bus.S_AWREADY, 1);
    chk("post-rst wready", bus.S_WREADY, 1);

    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].bresp,
               $sformatf("vec%0d wr", i));
      do_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp, $sformatf("vec%0d rd", i));
    end

    // W leads AW by three cycles; partial strobe merges into 0xDEADBEEF
    step();
    bus.S_WDATA = 32'h1122_3344; bus.S_WSTRB = 4'h5; bus.S_WVALID = 1'b1;
    #1;
    chk("early w wready", bus.S_WREADY, 1);
    step();
    bus.S_WVALID = 1'b0;
    chk("early w held", bus.S_WREADY, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("early w no bvalid %0d", i), bus.S_BVALID, 0);
    end
    step();
    bus.S_AWADDR = 32'h10; bus.S_AWVALID = 1'b1;
    #1;
    chk("late aw awready", bus.S_AWREADY, 1);
    step();
    bus.S_AWVALID = 1'b0;
    wait_bresp(2'b00, "early w");
    do_read(32'h10, 32'hDE22_BE44, 2'b00, "early w rd");

    // Write and read eligible together on every IDLE cycle
    rst = 1'b1; #2; rst = 1'b0;
    step();
    bus.S_AWADDR = 32'h20; bus.S_WDATA = 32'h0BAD_C0DE; bus.S_WSTRB = 4'hF;
    bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1; bus.S_BREADY = 1'b1; bus.S_RREADY = 1'b1;
    bus.S_ARADDR = 32'h20; bus.S_ARVALID = 1'b0;
    step();
    bus.S_ARVALID = 1'b1;
    #1;
    chk("rr first arready", bus.S_ARREADY, 0);
    gr = '0;
    ng = 0;
    n  = 0;
    while (ng < 4 && n < 40) begin
      step();
      n++;
      if (bus.S_BVALID || bus.S_RVALID) begin
        gr[ng] = bus.S_RVALID;
        ng++;
      end
    end
    chk("rr grant count", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr grant %0d is_read", i), gr[i], i % 2);
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0; bus.S_ARVALID = 1'b0;
    bus.S_BREADY = 1'b0; bus.S_RREADY = 1'b0;
    rst = 1'b1; #2; rst = 1'b0;

    // Stalled read response, then asynchronous reset mid-cycle
    do_write(32'h44, 32'h5A5A_C3C3, 4'hF, 2'b00, "stall wr");
    step();
    bus.S_ARADDR = 32'h44; bus.S_ARVALID = 1'b1;
    #1;
    n = 0;
    while (!bus.S_ARREADY && n < 20) begin
      step();
      n++;
    end
    chk("stall arready", bus.S_ARREADY, 1);
    step();
    bus.S_ARADDR = 32'h10;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall rvalid %0d", i), bus.S_RVALID, 1);
      chk($sformatf("stall rdata %0d", i), bus.S_RDATA, 32'h5A5A_C3C3);
      chk($sformatf("stall rresp %0d", i), bus.S_RRESP, 0);
      chk($sformatf("stall no new ar %0d", i), bus.S_ARREADY, 0);
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async rst rvalid", bus.S_RVALID, 0);
    chk("async rst rdata", bus.S_RDATA, 0);
    chk("async rst rresp", bus.S_RRESP, 0);
    chk("async rst arready", bus.S_ARREADY, 0);
    chk("async rst awready", bus.S_AWREADY, 0);
    chk("async rst wready", bus.S_WREADY, 0);
    chk("async rst bvalid", bus.S_BVALID, 0);
    chk("async rst bresp", bus.S_BRESP, 0);
    bus.S_ARVALID = 1'b0;
    #1;
    rst = 1'b0;
    step();
    chk("release awready", bus.S_AWREADY, 1);
    chk("release wready", bus.S_WREADY, 1);
    chk("release rvalid", bus.S_RVALID, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_sram_ctrl.md
AXIL_SRAM_CTRL -- requirements
Module: axil_sram_ctrl

Interface
REQ-001 DATA_W, 32, data width in bits; legal values are 32 and 64.
REQ-002 ADDR_W, 32, byte-address width.
REQ-003 DEPTH, 256, number of DATA_W-bit words held in the internal array; must be a power of two.
REQ-004 ACLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 ARESET  in  1  asynchronous, active-high reset.
REQ-006 S_AWADDR  in  ADDR_W  write byte address.
REQ-007 S_AWVALID  in  1  write address valid.
REQ-008 S_AWREADY  out  1  write address accepted.
REQ-009 S_WDATA  in  DATA_W  write data.
REQ-010 S_WSTRB  in  DATA_W/8  byte-lane enables.
REQ-011 S_WVALID  in  1  write data valid.
REQ-012 S_WREADY  out  1  write data accepted.
REQ-013 S_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
REQ-014 S_BVALID  out  1  write response valid.
REQ-015 S_BREADY  in  1  write response taken.
REQ-016 S_ARADDR  in  ADDR_W  read byte address.
REQ-017 S_ARVALID  in  1  read address valid.
REQ-018 S_ARREADY  out  1  read address accepted.
REQ-019 S_RDATA  out  DATA_W  read data.
REQ-020 S_RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
REQ-021 S_RVALID  out  1  read data valid.
REQ-022 S_RREADY  in  1  read data taken.

Function
REQ-023 The word index SHALL be ADDR[log2(DATA_W/8) +: log2(DEPTH)]; the low byte-offset bits SHALL be ignored, and any set bit above the index field SHALL make the access out of range.
REQ-024 AW and W SHALL be captured independently, in either order or in the same cycle, into holding registers: S_AWREADY = !aw_held and S_WREADY = !w_held, so at most one of each is held.
REQ-025 The FSM SHALL have the states IDLE, WR_RESP and RD_DATA, with only one transaction in flight.
REQ-026 In IDLE, a write is eligible when aw_held && w_held, and a read is eligible when S_ARVALID is high.
REQ-027 S_ARREADY SHALL be asserted only in IDLE, and only in a cycle where the read is granted.
REQ-028 When a write and a read are both eligible in the same cycle, a round-robin priority bit SHALL pick the winner; the bit resets to favour write and flips to the other type after every grant.
REQ-029 Write grant, in range: on the grant edge, each byte lane with WSTRB[i]=1 SHALL be updated and the other lanes left unchanged; the holding registers are cleared; the next cycle S_BVALID=1 with BRESP=00; state moves to WR_RESP.
REQ-030 Write grant, out of range: the array SHALL be left unmodified and BRESP=10; otherwise identical to REQ-029.
REQ-031 Read grant: S_RVALID SHALL rise on the cycle after the AR handshake (latency 1), with RDATA equal to the array word and RRESP=00, or with RDATA=0 and RRESP=10 when out of range; state moves to RD_DATA.
REQ-032 S_BVALID/S_BRESP and S_RVALID/S_RDATA/S_RRESP SHALL hold stable until the matching READY is seen high; on that edge VALID drops and state returns to IDLE.
REQ-033 New AW/W SHALL still be captured while in WR_RESP or RD_DATA, provided the holding registers are empty.
REQ-034 A read of a word written by the immediately preceding transaction SHALL return the new data (no stale read).

Reset
REQ-035 While ARESET=1 (asynchronous), all VALID and READY outputs, RESP outputs and RDATA SHALL be 0; the holding registers SHALL be emptied, the FSM forced to IDLE and the priority set to write; array contents are undefined. After release, S_AWREADY and S_WREADY SHALL be 1 in the first cycle, and any transaction in flight is discarded.

Structure
REQ-036 A shared package axil_pkg SHALL hold the RESP encodings (OKAY, SLVERR) and the FSM state enum.
REQ-037 The storage array SHALL be a sub-module axil_sram_bank (DATA_W, DEPTH; byte-write-enabled; synchronous single read port).

Verification (DATA_W=32, DEPTH=256)
REQ-038 AW 0x10 and W 0xDEADBEEF with STRB 0xF in the same cycle, then AR 0x10 -> BRESP=00, then RDATA=0xDEADBEEF with RRESP=00 on the cycle after the AR handshake.
REQ-039 W 0x11223344 with STRB 0x5 presented 3 cycles before AW 0x10 (word holds 0xDEADBEEF) -> a read returns 0xDE22BE44.
REQ-040 Write to AW 0x400 (out of range) -> BRESP=10; AR 0x400 -> RDATA=0 with RRESP=10; word 0 is unchanged.
REQ-041 Write and read eligible in the same IDLE cycle, repeated 4 times -> grants follow the order W, R, W, R.
REQ-042 S_RREADY held low for 5 cycles -> RVALID and RDATA stay stable and no new AR is accepted; ARESET pulsed mid-way -> all outputs are 0 asynchronously.
